// File: rtl/led_pwm_ctrl_pkg.sv
// Shared defaults, green-channel state encodings and a counter-width helper
// for the led_pwm_ctrl block.
package led_pwm_ctrl_pkg;

    localparam int DEF_PWM_BITS   = 8;
    localparam int DEF_PRESCALE   = 188;
    localparam int DEF_STEP       = 32;
    localparam int DEF_HB_PERIODS = 500;

    typedef enum logic {
        HB_OFF = 1'b0,
        HB_ON  = 1'b1
    } hb_state_e;

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_state_e;

    // Width of a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Button inputs and PWM/level outputs of led_pwm_ctrl bundled as one port.
// slave = the controller, master = whoever drives the buttons.
interface led_pwm_ctrl_if #(
    parameter int PWM_BITS = 8
);
    logic                btn_blue_n;
    logic                btn_red_n;
    logic                blue_pwm;
    logic                red_pwm;
    logic                green_pwm;
    logic [PWM_BITS-1:0] blue_level;
    logic [PWM_BITS-1:0] red_level;

    modport master (
        output btn_blue_n, btn_red_n,
        input  blue_pwm, red_pwm, green_pwm, blue_level, red_level
    );

    modport slave (
        input  btn_blue_n, btn_red_n,
        output blue_pwm, red_pwm, green_pwm, blue_level, red_level
    );
endinterface

// File: rtl/led_pwm_ctrl_pwm_chan.sv
// One PWM channel: shadow duty register reloaded only at period end, so a
// duty change never cuts a pulse short, followed by a registered compare.
module led_pwm_ctrl_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm,
    output logic [PWM_BITS-1:0] level
);
    logic [PWM_BITS-1:0] active_q, active_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        active_d = active_q;
        if (period_end) begin
            active_d = duty;
        end
        pwm_d = (pwm_cnt < active_q);
    end

    // NOTE: state flops use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm   = pwm_q;
    assign level = active_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Button-stepped blue/red PWM brightness plus green heartbeat for the RGB driver.
// Define LED_BREATHE_EN to turn the green square heartbeat into a triangle ramp.
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int STEP       = DEF_STEP,
    parameter int HB_PERIODS = DEF_HB_PERIODS
) (
    input  logic          clk,
    input  logic          rst_n,
    led_pwm_ctrl_if.slave bus
);
    localparam int                  PRE_W    = cnt_width(PRESCALE);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    // Sync bits: [0] first stage, [1] second stage, [2] previous second stage.
    logic [2:0]          blue_sync_q, blue_sync_d, red_sync_q, red_sync_d;
    logic                blue_press, red_press;
    logic [PWM_BITS-1:0] blue_duty_q, blue_duty_d, red_duty_q, red_duty_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick, period_end;
    logic [PWM_BITS-1:0] green_duty;
    logic [PWM_BITS-1:0] green_level_unused;

    always_comb begin
        blue_sync_d = {blue_sync_q[1:0], bus.btn_blue_n};
        red_sync_d  = {red_sync_q[1:0], bus.btn_red_n};
        blue_press  = blue_sync_q[2] & ~blue_sync_q[1];
        red_press   = red_sync_q[2] & ~red_sync_q[1];
        blue_duty_d = blue_press ? blue_duty_q + PWM_BITS'(STEP) : blue_duty_q;
        red_duty_d  = red_press  ? red_duty_q  + PWM_BITS'(STEP) : red_duty_q;

        tick       = (pre_cnt_q == PRE_W'(PRESCALE - 1));
        pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d  = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        period_end = tick && (pwm_cnt_q == DUTY_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronisers idle at "released" so reset release is never a press.
            blue_sync_q <= 3'b111;
            red_sync_q  <= 3'b111;
            blue_duty_q <= '0;
            red_duty_q  <= '0;
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            blue_sync_q <= blue_sync_d;
            red_sync_q  <= red_sync_d;
            blue_duty_q <= blue_duty_d;
            red_duty_q  <= red_duty_d;
            pre_cnt_q   <= pre_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

`ifdef LED_BREATHE_EN
    ramp_state_e         ramp_q, ramp_d;
    logic [PWM_BITS-1:0] g_duty_q, g_duty_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q   <= RAMP_UP;
            g_duty_q <= '0;
        end else begin
            ramp_q   <= ramp_d;
            g_duty_q <= g_duty_d;
        end
    end

    always_comb begin
        ramp_d   = ramp_q;
        g_duty_d = g_duty_q;
        if (period_end) begin
            case (ramp_q)
                RAMP_UP: begin
                    g_duty_d = g_duty_q + PWM_BITS'(1);
                    if (g_duty_q == DUTY_MAX - PWM_BITS'(1)) ramp_d = RAMP_DOWN;
                end
                default: begin
                    g_duty_d = g_duty_q - PWM_BITS'(1);
                    if (g_duty_q == PWM_BITS'(1)) ramp_d = RAMP_UP;
                end
            endcase
        end
    end

    always_comb begin
        green_duty = g_duty_q;
    end
`else
    localparam int HB_W = cnt_width(HB_PERIODS);

    hb_state_e       hb_q, hb_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_q     <= HB_OFF;
            hb_cnt_q <= '0;
        end else begin
            hb_q     <= hb_d;
            hb_cnt_q <= hb_cnt_d;
        end
    end

    always_comb begin
        hb_d     = hb_q;
        hb_cnt_d = hb_cnt_q;
        if (period_end) begin
            if (hb_cnt_q == HB_W'(HB_PERIODS - 1)) begin
                hb_d     = (hb_q == HB_ON) ? HB_OFF : HB_ON;
                hb_cnt_d = '0;
            end else begin
                hb_cnt_d = hb_cnt_q + HB_W'(1);
            end
        end
    end

    always_comb begin
        green_duty = (hb_q == HB_ON) ? DUTY_MAX : '0;
    end
`endif

    led_pwm_ctrl_pwm_chan #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .period_end(period_end),
        .duty(blue_duty_q), .pwm(bus.blue_pwm), .level(bus.blue_level)
    );

    led_pwm_ctrl_pwm_chan #(.PWM_BITS(PWM_BITS)) u_red (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .period_end(period_end),
        .duty(red_duty_q), .pwm(bus.red_pwm), .level(bus.red_level)
    );

    led_pwm_ctrl_pwm_chan #(.PWM_BITS(PWM_BITS)) u_green (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .period_end(period_end),
        .duty(green_duty), .pwm(bus.green_pwm), .level(green_level_unused)
    );

endmodule
